if_fetch: RTL and testbench
===========================

# if_fetch

Instruction fetch unit feeding the IF_ID pipeline register. Keeps the PC and assembles each 32-bit instruction from four byte reads on the shared byte-wide memory port, which it reaches through the memory arbiter. It presents `if_pc`/`if_inst` together with a stall request that makes IF_ID load a bubble. It accepts branch/jump redirects (`use_npc`/`npc_addr`) from ID and optionally serves hits from a direct-mapped instruction cache.

## Interface
- `IDX_W`, 6: cache index width, giving 2^IDX_W word entries. Used only with `ICACHE_EN`.
- `clk` input 1: the only clock.
- `rst` input 1: synchronous, active-high reset.
- `rdy` input 1: global ready. When low, all state is frozen.
- `use_npc` input 1: redirect request from ID.
- `npc_addr` input 17: redirect target.
- `hold` input 1: downstream hold (stall[1]). IF_ID is not accepting.
- `mem_req` output 1: byte read request to the arbiter.
- `mem_addr` output 17: byte address.
- `mem_gnt` input 1: arbiter granted `mem_addr` this cycle.
- `mem_din` input 8: read data, valid the cycle after a grant.
- `if_pc` output 17: PC of the presented instruction.
- `if_inst` output 32: presented instruction.
- `if_valid` output 1: `if_pc`/`if_inst` hold a valid instruction.
- `stall_req` output 1: drives stall[0]. Equals `~if_valid | use_npc`.

## Operation
- Registers:
  - `pc` (17 b)
  - FSM state {IDLE, FETCH}
  - `cnt_a` (granted addresses, 0..4)
  - `cnt_d` (received bytes, 0..4)
  - `drop` flag
  - 32 b byte assembly buffer
- **Reset values:** all outputs 0, `pc`=0, state IDLE, counters 0, `drop`=0, all cache valid bits cleared.
- **Accept condition:** `accept` = `rdy & if_valid & ~hold & ~use_npc`. On accept, `if_valid` clears unless a new instruction loads on the same edge.
- **Engine free:** the engine is free when `~if_valid | accept`.
- **IDLE, engine free:**
  - Cache hit (`ICACHE_EN`): load `if_inst` from the cache, `if_pc`=`pc`, set `if_valid`=1, `pc`+=4. State stays IDLE.
  - Miss: `mem_req`=1 with `mem_addr`=`pc`. On grant, `cnt_a`=1 and go to FETCH.
- **FETCH:**
  - `mem_req`=1 while `cnt_a`<4, with `mem_addr`=`pc`+`cnt_a`. Each grant increments `cnt_a`.
  - Each valid byte is stored little-endian: byte k goes to `inst[8k+7:8k]`, and `cnt_d` increments.
  - When the 4th byte arrives: `if_inst`=assembled word, `if_pc`=`pc`, `if_valid`=1, `pc`+=4, cache entry written, state returns to IDLE.
  - FETCH never starts the next instruction early, because `if_valid` is already set.
- **Redirect:**
  - `use_npc`=1 with `rdy` has priority over `hold` and FETCH.
  - Effects: `pc`=`npc_addr`, `if_valid`=0, counters 0, state IDLE, and `mem_req` forced 0 that cycle.
  - If a byte was granted in the cycle before the redirect, its data arrives in the redirect cycle and is ignored.
  - If a grant lands in the redirect cycle itself, `drop`=1 and the byte arriving next cycle is discarded. `drop` then clears.
- **Hold:** while `if_valid`=1 and `hold`=1, outputs and `pc` stay constant and no new fetch starts.
- **Address arithmetic:** `pc`+4 and `pc`+k are modulo 2^17, so 0x1FFFC+4 wraps to 0x00000. No alignment is forced.
- **`rdy`=0:** no register updates, `mem_req`=0, `mem_din` is ignored. The arbiter re-presents in-flight data once `rdy` is high.

## Timing
- `mem_req` and `mem_addr` are combinational from state. `stall_req` is combinational from `if_valid` and `use_npc`. All other outputs are registered.
- **Miss latency:**
  - Byte reads pipeline: address k+1 is issued in the same cycle that byte k returns.
  - With continuous grant, the IDLE request is in cycle 0 and bytes arrive in cycles 1–4.
  - `if_valid` rises in cycle 5. The fastest miss throughput is therefore one instruction per 5 cycles.
  - Each cycle without a grant adds one cycle.
- **Hit latency:** `if_valid` rises 1 cycle after IDLE. Back-to-back hits with `hold`=0 deliver one instruction per cycle.
- **Redirect to first request:** the redirect cycle issues no request. The request to `npc_addr` is issued the following cycle.

## Configuration
- **`ICACHE_EN` defined:**
  - Direct-mapped cache of 2^IDX_W words: valid bit, tag `pc[16:IDX_W+2]`, index `pc[IDX_W+1:2]`.
  - The hit check is combinational in IDLE.
  - The cache is filled on every completed miss. It is never invalidated except by reset.
- **`ICACHE_EN` undefined:** no cache storage. Every fetch takes the miss path.

## Test plan
- **Reset:** hold `rst` 2 cycles, then release with `mem_gnt`=1 and bytes 0x13, 0x05, 0x10, 0x00.
  - Required: `mem_addr` 0, 1, 2, 3.
  - Required: `if_valid` in cycle 5 with `if_pc`=0x00000 and `if_inst`=0x00100513, then `pc`=4.
- **Grant gaps:** `mem_gnt` low for 2 cycles after byte 1 is granted.
  - Required: `if_valid` is delayed by exactly 2 cycles and `if_inst` is unchanged.
- **Redirect mid-FETCH:** after 2 bytes, pulse `use_npc` with `npc_addr`=0x00100.
  - Required: that cycle has `mem_req`=0 and `stall_req`=1.
  - Required: the next request is at 0x00100.
  - Required: the stale byte is discarded, and the new instruction assembles only from bytes 0x00100–0x00103.
- **Hold:** set `hold`=1 for 3 cycles while `if_valid`=1.
  - Required: `if_pc`, `if_inst` and `pc` are stable, with no `mem_req`. Release gives `accept` on the next edge.
- **`ICACHE_EN`, cache hit:** fetch 0x0..0xC, then redirect to 0x0.
  - Required: four instructions at 1 cycle each, no `mem_req`, identical data.
- **`rdy` low:** drop `rdy` for 3 cycles mid-FETCH.
  - Required: counters, `pc` and outputs are frozen and `mem_req`=0. Assembly resumes correctly once `rdy` returns.

Source files
------------

// File: rtl/if_fetch.sv
// Instruction fetch unit: keeps the PC and assembles 32-bit words from four byte reads.
// Define ICACHE_EN to add a direct-mapped instruction cache of 2^IDX_W words.
module if_fetch #(
   parameter int IDX_W = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        use_npc,
   input  logic [16:0] npc_addr,
   input  logic        hold,
   output logic        mem_req,
   output logic [16:0] mem_addr,
   input  logic        mem_gnt,
   input  logic [7:0]  mem_din,
   output logic [16:0] if_pc,
   output logic [31:0] if_inst,
   output logic        if_valid,
   output logic        stall_req
);
   typedef enum logic {IDLE, FETCH} state_t;

   state_t      state, state_next;
   logic [16:0] pc;
   logic [2:0]  cnt_a, cnt_d;
   logic        drop, pend;
   logic [23:0] asm_buf;

   logic        redirect, accept, free, grant, byte_ok, last_byte, hit;
   logic [31:0] full_word, hit_word;

   assign redirect  = rdy & use_npc;
   assign accept    = rdy & if_valid & ~hold & ~use_npc;
   assign free      = ~if_valid | accept;
   assign byte_ok   = pend & ~drop;
   assign last_byte = byte_ok & (cnt_d == 3'd3);
   assign full_word = {mem_din, asm_buf};
   assign stall_req = ~if_valid | use_npc;

   assign mem_req  = ~rst & rdy & ~use_npc &
                     (((state == IDLE) & free & ~hit) | ((state == FETCH) & (cnt_a < 3'd4)));
   assign mem_addr = pc + 17'(cnt_a);
   assign grant    = mem_req & mem_gnt;

`ifdef ICACHE_EN
   localparam int TAG_W   = 15 - IDX_W;
   localparam int ENTRIES = 1 << IDX_W;

   logic [TAG_W-1:0]   tag_mem  [ENTRIES];
   logic [31:0]        data_mem [ENTRIES];
   logic [ENTRIES-1:0] valid_mem;
   logic [IDX_W-1:0]   idx;
   logic               fill;

   assign idx      = pc[IDX_W+1:2];
   assign fill     = rdy & ~use_npc & (state == FETCH) & last_byte;
   assign hit      = (state == IDLE) & valid_mem[idx] & (tag_mem[idx] == pc[16:IDX_W+2]);
   assign hit_word = data_mem[idx];

   always_ff @(posedge clk) begin
      if (rst)
         valid_mem <= '0;
      else if (fill)
         valid_mem[idx] <= 1'b1;
   end

   always_ff @(posedge clk) begin
      if (fill) begin
         tag_mem[idx]  <= pc[16:IDX_W+2];
         data_mem[idx] <= full_word;
      end
   end
`else
   // Without the cache IDX_W has no effect and every fetch misses.
   assign hit      = (IDX_W < 0);
   assign hit_word = '0;
`endif

   always_comb begin
      state_next = state;
      if (rdy) begin
         if (use_npc)
            state_next = IDLE;
         else if (state == IDLE) begin
            if (grant)
               state_next = FETCH;
         end else if (last_byte)
            state_next = IDLE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_next;
   end

   // A redirect discards any byte already in flight; drop also covers a grant landing on it.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc       <= '0;
         cnt_a    <= '0;
         cnt_d    <= '0;
         drop     <= 1'b0;
         pend     <= 1'b0;
         asm_buf  <= '0;
         if_pc    <= '0;
         if_inst  <= '0;
         if_valid <= 1'b0;
      end else if (rdy) begin
         drop <= 1'b0;
         pend <= grant;
         if (accept)
            if_valid <= 1'b0;
         if (redirect) begin
            pc       <= npc_addr;
            if_valid <= 1'b0;
            cnt_a    <= '0;
            cnt_d    <= '0;
            drop     <= mem_gnt;
            pend     <= mem_gnt;
         end else if (state == IDLE) begin
            if (free & hit) begin
               if_inst  <= hit_word;
               if_pc    <= pc;
               if_valid <= 1'b1;
               pc       <= pc + 17'd4;
            end else if (grant)
               cnt_a <= 3'd1;
         end else begin
            if (grant)
               cnt_a <= cnt_a + 3'd1;
            if (last_byte) begin
               if_inst  <= full_word;
               if_pc    <= pc;
               if_valid <= 1'b1;
               pc       <= pc + 17'd4;
               cnt_a    <= '0;
               cnt_d    <= '0;
            end else if (byte_ok) begin
               case (cnt_d[1:0])
                  2'd0:    asm_buf[7:0]   <= mem_din;
                  2'd1:    asm_buf[15:8]  <= mem_din;
                  default: asm_buf[23:16] <= mem_din;
               endcase
               cnt_d <= cnt_d + 3'd1;
            end
         end
      end
   end
endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios pinned by literal values, then
// randomized rdy/hold/grant/redirect traffic checked against an instruction-stream model.
module tb_if_fetch;
   logic        clk = 1'b0;
   logic        rst, rdy, use_npc, hold, mem_gnt;
   logic [16:0] npc_addr;
   logic [7:0]  mem_din;
   logic        mem_req, if_valid, stall_req;
   logic [16:0] mem_addr, if_pc;
   logic [31:0] if_inst;

   always #5 clk = ~clk;

   if_fetch #(.IDX_W(6)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .use_npc(use_npc), .npc_addr(npc_addr),
      .hold(hold), .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
      .mem_din(mem_din), .if_pc(if_pc), .if_inst(if_inst), .if_valid(if_valid),
      .stall_req(stall_req)
   );

   logic [7:0]  mem [0:131071];
   int          tests = 0;
   int          fails = 0;

   logic        s_rdy, s_npc_v, s_hold, s_gnt;
   logic [16:0] s_npc;

   logic        arb_pend;
   logic [16:0] arb_addr;

   logic [16:0] model_pc;
   int          nb;
   int          starve;

   logic        p_valid, p_accept, p_redirect, p_grant, p_rdy, p_gnt_raw;
   logic [16:0] p_npc, p_pc, p_gaddr;
   logic [31:0] p_inst;
   logic        last_req, last_stall;
   logic [16:0] last_addr;

   function automatic logic [31:0] word_at(input logic [16:0] a);
      logic [16:0] a1, a2, a3;
      a1 = a + 17'd1;
      a2 = a + 17'd2;
      a3 = a + 17'd3;
      return {mem[a3], mem[a2], mem[a1], mem[a]};
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // The arbiter returns the granted byte one cycle later and re-presents it while rdy is low.
   task automatic applyStimulus();
      rst      = 1'b0;
      rdy      = s_rdy;
      use_npc  = s_npc_v;
      npc_addr = s_npc;
      hold     = s_hold;
      mem_gnt  = s_gnt;
      mem_din  = arb_pend ? mem[arb_addr] : 8'($urandom);
   endtask

   task automatic runCycle();
      logic        exp_stall;
      logic [16:0] exp_addr;
      @(negedge clk);
      applyStimulus();
      #1;
      last_req   = mem_req;
      last_addr  = mem_addr;
      last_stall = stall_req;
      exp_stall  = ~if_valid | use_npc;
      checkOutput("stall_req", 32'(stall_req), 32'(exp_stall));
      if (!rdy || use_npc)
         checkOutput("mem_req_blocked", 32'(mem_req), 32'h0);
      else if (if_valid && hold)
         checkOutput("mem_req_hold", 32'(mem_req), 32'h0);
      p_grant = rdy & mem_req & mem_gnt;
      if (p_grant) begin
         exp_addr = model_pc + 17'(nb);
         checkOutput("grant_count_le4", 32'(nb < 4), 32'h1);
         checkOutput("mem_addr", 32'(mem_addr), 32'(exp_addr));
         nb++;
      end
      p_valid    = if_valid;
      p_accept   = rdy & if_valid & ~hold & ~use_npc;
      p_redirect = rdy & use_npc;
      p_npc      = npc_addr;
      p_pc       = if_pc;
      p_inst     = if_inst;
      p_gaddr    = mem_addr;
      p_rdy      = rdy;
      p_gnt_raw  = mem_gnt;
      @(posedge clk);
      #1;
      if (p_rdy) begin
         arb_pend = p_gnt_raw;
         arb_addr = p_gaddr;
      end
      if (p_redirect) begin
         model_pc = p_npc;
         nb       = 0;
         checkOutput("redirect_clears_valid", 32'(if_valid), 32'h0);
      end else if (if_valid && (!p_valid || p_accept)) begin
         checkOutput("if_pc", 32'(if_pc), 32'(model_pc));
         checkOutput("if_inst", if_inst, word_at(model_pc));
         model_pc = model_pc + 17'd4;
         nb       = 0;
      end else if (p_valid && !p_accept) begin
         checkOutput("held_valid", 32'(if_valid), 32'h1);
         checkOutput("held_pc", 32'(if_pc), 32'(p_pc));
         checkOutput("held_inst", if_inst, p_inst);
      end
      if (!if_valid && p_rdy)
         starve++;
      else
         starve = 0;
      if (starve > 400) begin
         checkOutput("fetch_timeout", 32'(starve), 32'h0);
         starve = 0;
      end
   endtask

   logic [16:0] a_addr [5];
   logic        a_req  [5];
   logic        a_val  [5];

   initial begin
      for (int i = 0; i < 131072; i++)
         mem[i] = 8'($urandom);
      {mem[0], mem[1], mem[2], mem[3]}                 = {8'h13, 8'h05, 8'h10, 8'h00};
      {mem[4], mem[5], mem[6], mem[7]}                 = {8'h93, 8'h00, 8'h10, 8'h00};
      {mem['h100], mem['h101], mem['h102], mem['h103]} = {8'hB7, 8'h12, 8'h34, 8'h00};
      {mem['h104], mem['h105], mem['h106], mem['h107]} = {8'h33, 8'h85, 8'hA5, 8'h00};

      rst = 1'b1; rdy = 1'b1; use_npc = 1'b0; npc_addr = '0; hold = 1'b0;
      mem_gnt = 1'b1; mem_din = '0;
      arb_pend = 1'b0; arb_addr = '0;
      model_pc = '0; nb = 0; starve = 0;
      s_rdy = 1'b1; s_npc_v = 1'b0; s_npc = '0; s_hold = 1'b1; s_gnt = 1'b1;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_if_valid", 32'(if_valid), 32'h0);
      checkOutput("reset_if_pc", 32'(if_pc), 32'h0);
      checkOutput("reset_if_inst", if_inst, 32'h0);
      checkOutput("reset_mem_req", 32'(mem_req), 32'h0);

      // First miss with continuous grant
      for (int i = 0; i < 5; i++) begin
         runCycle();
         a_addr[i] = last_addr;
         a_req[i]  = last_req;
         a_val[i]  = if_valid;
      end
      for (int i = 0; i < 4; i++) begin
         checkOutput("first_req", 32'(a_req[i]), 32'h1);
         checkOutput("first_addr", 32'(a_addr[i]), i);
      end
      checkOutput("first_no_req_c4", 32'(a_req[4]), 32'h0);
      checkOutput("first_valid_c4", 32'(a_val[3]), 32'h0);
      checkOutput("first_valid_c5", 32'(a_val[4]), 32'h1);
      checkOutput("first_pc", 32'(if_pc), 32'h0);
      checkOutput("first_inst", if_inst, 32'h00100513);

      // Hold for three cycles, then release with grant gaps
      repeat (3) begin
         runCycle();
         checkOutput("hold_no_req", 32'(last_req), 32'h0);
      end
      checkOutput("hold_pc", 32'(if_pc), 32'h0);
      checkOutput("hold_inst", if_inst, 32'h00100513);
      s_hold = 1'b0;
      runCycle();
      checkOutput("release_req", 32'(last_req), 32'h1);
      checkOutput("release_addr", 32'(last_addr), 32'h4);
      s_hold = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         s_gnt = (i == 2 || i == 3) ? 1'b0 : 1'b1;
         runCycle();
         if (i == 5)
            checkOutput("gap_valid_c5", 32'(if_valid), 32'h0);
      end
      checkOutput("gap_valid_c6", 32'(if_valid), 32'h1);
      checkOutput("gap_pc", 32'(if_pc), 32'h4);
      checkOutput("gap_inst", if_inst, 32'h00100093);

      // Redirect after two bytes, with a grant landing on the redirect cycle
      s_gnt = 1'b1; s_hold = 1'b0;
      runCycle();
      checkOutput("fetch8_addr", 32'(last_addr), 32'h8);
      s_hold = 1'b1;
      repeat (2) runCycle();
      s_npc_v = 1'b1; s_npc = 17'h00100;
      runCycle();
      checkOutput("redir_mem_req", 32'(last_req), 32'h0);
      checkOutput("redir_stall", 32'(last_stall), 32'h1);
      s_npc_v = 1'b0;
      runCycle();
      checkOutput("redir_first_req", 32'(last_req), 32'h1);
      checkOutput("redir_first_addr", 32'(last_addr), 32'h100);
      repeat (3) runCycle();
      checkOutput("redir_valid_early", 32'(if_valid), 32'h0);
      runCycle();
      checkOutput("redir_valid", 32'(if_valid), 32'h1);
      checkOutput("redir_pc", 32'(if_pc), 32'h100);
      checkOutput("redir_inst", if_inst, 32'h003412B7);

      // rdy low for three cycles mid-FETCH
      s_hold = 1'b0;
      runCycle();
      checkOutput("rdy_start_addr", 32'(last_addr), 32'h104);
      s_hold = 1'b1;
      runCycle();
      s_rdy = 1'b0;
      repeat (3) begin
         runCycle();
         checkOutput("rdy_low_req", 32'(last_req), 32'h0);
         checkOutput("rdy_low_addr", 32'(last_addr), 32'h106);
         checkOutput("rdy_low_valid", 32'(if_valid), 32'h0);
      end
      s_rdy = 1'b1;
      repeat (2) runCycle();
      checkOutput("rdy_valid_early", 32'(if_valid), 32'h0);
      runCycle();
      checkOutput("rdy_valid", 32'(if_valid), 32'h1);
      checkOutput("rdy_pc", 32'(if_pc), 32'h104);
      checkOutput("rdy_inst", if_inst, 32'h00A58533);

`ifdef ICACHE_EN
      // Words 0x0 and 0x4 were filled earlier and now hit back to back
      s_npc_v = 1'b1; s_npc = 17'h0;
      runCycle();
      s_npc_v = 1'b0; s_hold = 1'b0;
      runCycle();
      checkOutput("hit0_no_req", 32'(last_req), 32'h0);
      checkOutput("hit0_valid", 32'(if_valid), 32'h1);
      checkOutput("hit0_pc", 32'(if_pc), 32'h0);
      checkOutput("hit0_inst", if_inst, 32'h00100513);
      runCycle();
      checkOutput("hit1_no_req", 32'(last_req), 32'h0);
      checkOutput("hit1_pc", 32'(if_pc), 32'h4);
      checkOutput("hit1_inst", if_inst, 32'h00100093);
`endif

      // Randomized traffic, including redirects near the top of the address space
      for (int i = 0; i < 4000; i++) begin
         s_rdy   = ($urandom_range(7) != 0);
         s_npc_v = ($urandom_range(19) == 0);
         s_hold  = ($urandom_range(3) == 0);
         s_gnt   = ($urandom_range(2) != 0);
         case ($urandom_range(3))
            0:       s_npc = 17'h1FFFC;
            1:       s_npc = 17'h1FFFE;
            default: s_npc = 17'($urandom_range(511));
         endcase
         runCycle();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
